// File: rtl/x_200_mod_241_loader.sv
// Operand sequencer for the 200-bit mod-241 reducer.
// Collects an LSB-first byte stream into the reducer's X input. Samples the
// reducer's combinational residue one cycle after the operand is complete.
// Returns it on a valid/ready result port together with a framing-error flag.

// One operand byte slot. A write takes priority over a clear, so slot 0 can
// take the first beat in the same cycle that every other slot is being zeroed.
module x_200_mod_241_loader_slot #(
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr,
  input  logic              i_clr,
  input  logic [BYTE_W-1:0] i_data,
  output logic [BYTE_W-1:0] o_q
);
  logic [BYTE_W-1:0] r_q;

  // slot storage: load on write, zero on clear, otherwise hold
  always_ff @(posedge clk) begin
    if (!rst_n)     r_q <= '0;
    else if (i_wr)  r_q <= i_data;
    else if (i_clr) r_q <= '0;
  end

  assign o_q = r_q;
endmodule

module x_200_mod_241_loader #(
  parameter int BYTE_W    = 8,
  parameter int NUM_BYTES = 25,
  parameter int R_W       = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [BYTE_W-1:0]           in_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [BYTE_W*NUM_BYTES-1:0] x_out,
  input  logic [R_W-1:0]              r_in,
  output logic [R_W-1:0]              res_data,
  output logic                        res_err,
  output logic                        res_valid,
  input  logic                        res_ready
);
  localparam int CNT_W = $clog2(NUM_BYTES);

  typedef enum logic [1:0] {S_LOAD, S_CALC, S_HOLD} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_in_ready;
  logic              r_err_pend;
  logic [R_W-1:0]    r_res_data;
  logic              r_res_err;
  logic              r_res_valid;

  logic              w_acc;
  logic              w_first;
  logic              w_full;
  logic              w_done;
  logic [NUM_BYTES-1:0][BYTE_W-1:0] w_slot;

  // in_ready is only ever high in LOAD, so acceptance implies LOAD
  assign w_acc   = in_valid & r_in_ready;
  assign w_first = w_acc & (r_cnt == '0);
  assign w_full  = (r_cnt == CNT_W'(NUM_BYTES-1));
  assign w_done  = w_acc & (in_last | w_full);

  // Byte slots. The first beat of an operand zeroes every other slot, so short
  // operands are zero-extended. The previous operand stays visible on x_out
  // until that first beat.
  for (genvar g = 0; g < NUM_BYTES; g++) begin : g_slot
    logic w_wr;
    logic w_clr;
    assign w_wr = w_acc & (r_cnt == CNT_W'(g));
    if (g == 0) begin : g_lsb
      assign w_clr = 1'b0;
    end else begin : g_upper
      assign w_clr = w_first;
    end
    x_200_mod_241_loader_slot #(.BYTE_W(BYTE_W)) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_wr   (w_wr),
      .i_clr  (w_clr),
      .i_data (in_data),
      .o_q    (w_slot[g])
    );
  end

  assign x_out = w_slot;

  // Control FSM: LOAD collects beats, CALC samples the reducer, HOLD waits for
  // the result handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_LOAD;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_err_pend  <= 1'b0;
      r_res_data  <= '0;
      r_res_err   <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_acc) begin
            if (w_done) begin
              // cnt is left in place here and cleared on the handshake, so it
              // never passes NUM_BYTES-1
              r_state    <= S_CALC;
              r_in_ready <= 1'b0;
              r_err_pend <= w_full & ~in_last;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_CALC: begin
          // x_out has been stable for a full cycle, so r_in has settled
          r_res_data  <= r_in;
          r_res_err   <= r_err_pend;
          r_res_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_state     <= S_LOAD;
          end
        end
        default: begin
          r_state    <= S_LOAD;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign res_data  = r_res_data;
  assign res_err   = r_res_err;
  assign res_valid = r_res_valid;
endmodule

// File: tb/tb_x_200_mod_241_loader.sv
// Directed bench for the mod-241 operand loader, with a behavioural reducer on r_in.
module tb_x_200_mod_241_loader;
  logic         clk;
  logic         rst_n;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [199:0] x_out;
  logic [7:0]   r_in;
  logic [7:0]   res_data;
  logic         res_err;
  logic         res_valid;
  logic         res_ready;

  logic [199:0] w_mod;
  int checks = 0;
  int errors = 0;

  // stand-in for the combinational reducer
  assign w_mod = x_out % 200'd241;
  assign r_in  = w_mod[7:0];

  x_200_mod_241_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .x_out     (x_out),
    .r_in      (r_in),
    .res_data  (res_data),
    .res_err   (res_err),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Horner evaluation of a byte array (index 0 = LSB) modulo 241
  function automatic int mod_ref(input logic [7:0] b [25]);
    int acc = 0;
    for (int i = 24; i >= 0; i--) acc = (acc * 256 + int'(b[i])) % 241;
    return acc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pop();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0 || res_err !== 1'b0 ||
        res_data !== 8'h00 || x_out !== 200'd0) begin
      errors++;
      $display("FAIL reset: in_ready=%b res_valid=%b res_err=%b res_data=%h x_out=%h want 1 0 0 00 0",
               in_ready, res_valid, res_err, res_data, x_out);
    end
  endtask

  task automatic test_all_ff();
    for (int k = 0; k < 25; k++) send_beat(8'hFF, k == 24);
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b0 || x_out !== {200{1'b1}}) begin
      errors++;
      $display("FAIL all_ff_calc: res_valid=%b in_ready=%b x_out=%h want 0 0 all-ones",
               res_valid, in_ready, x_out);
    end
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 8'h0E || res_err !== 1'b0) begin
      errors++;
      $display("FAIL all_ff_result: valid=%b data=%h err=%b want 1 0e 0", res_valid, res_data, res_err);
    end
    pop();
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL all_ff_pop: res_valid=%b in_ready=%b want 0 1", res_valid, in_ready);
    end
  endtask

  task automatic test_short();
    send_beat(8'hF0, 1'b1);
    checks++;
    if (x_out !== 200'd240) begin
      errors++;
      $display("FAIL short_f0_x: x_out=%h want f0", x_out);
    end
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 8'hF0 || res_err !== 1'b0) begin
      errors++;
      $display("FAIL short_f0: valid=%b data=%h err=%b want 1 f0 0", res_valid, res_data, res_err);
    end
    pop();
    send_beat(8'hF1, 1'b1);
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 8'h00 || res_err !== 1'b0) begin
      errors++;
      $display("FAIL short_f1: valid=%b data=%h err=%b want 1 00 0", res_valid, res_data, res_err);
    end
    pop();
  endtask

  task automatic test_clear();
    for (int k = 0; k < 25; k++) send_beat(8'hFF, k == 24);
    tick();
    pop();
    send_beat(8'h00, 1'b0);
    send_beat(8'h01, 1'b1);
    checks++;
    if (x_out !== 200'd256) begin
      errors++;
      $display("FAIL clear_x: x_out=%h want 100", x_out);
    end
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 8'h0F || res_err !== 1'b0) begin
      errors++;
      $display("FAIL clear_result: valid=%b data=%h err=%b want 1 0f 0", res_valid, res_data, res_err);
    end
    pop();
  endtask

  task automatic test_framing();
    for (int k = 0; k < 25; k++) send_beat(8'h01, 1'b0);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL framing_stop: in_ready=%b want 0", in_ready);
    end
    tick();
    // sum of 256^k for k<25 is congruent to 1 mod 241
    checks++;
    if (res_valid !== 1'b1 || res_data !== 8'h01 || res_err !== 1'b1) begin
      errors++;
      $display("FAIL framing_err: valid=%b data=%h err=%b want 1 01 1", res_valid, res_data, res_err);
    end
    pop();
    send_beat(8'h05, 1'b1);
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 8'h05 || res_err !== 1'b0 || x_out !== 200'd5) begin
      errors++;
      $display("FAIL framing_next: valid=%b data=%h err=%b x_out=%h want 1 05 0 5",
               res_valid, res_data, res_err, x_out);
    end
    pop();
  endtask

  task automatic test_hold();
    send_beat(8'hAB, 1'b1);
    tick();
    // offer a beat while the result is pending; it must not be taken
    in_data  = 8'h33;
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_data !== 8'hAB || res_err !== 1'b0 ||
          in_ready !== 1'b0 || x_out !== 200'hAB) begin
        errors++;
        $display("FAIL hold_stable c=%0d: valid=%b data=%h err=%b in_ready=%b x_out=%h want 1 ab 0 0 ab",
                 c, res_valid, res_data, res_err, in_ready, x_out);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    pop();
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: res_valid=%b in_ready=%b want 0 1", res_valid, in_ready);
    end
    tick();
    checks++;
    if (res_valid !== 1'b0 || x_out !== 200'hAB) begin
      errors++;
      $display("FAIL hold_single: res_valid=%b x_out=%h want 0 ab", res_valid, x_out);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b [25];
    int exp;
    for (int k = 0; k < 10; k++) send_beat(8'h77, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0 || res_err !== 1'b0 ||
        res_data !== 8'h00 || x_out !== 200'd0) begin
      errors++;
      $display("FAIL reset_mid: in_ready=%b res_valid=%b res_err=%b res_data=%h x_out=%h want 1 0 0 00 0",
               in_ready, res_valid, res_err, res_data, x_out);
    end
    for (int k = 0; k < 25; k++) b[k] = 8'(k * 7 + 3);
    exp = mod_ref(b);
    for (int k = 0; k < 25; k++) send_beat(b[k], k == 24);
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 8'(exp) || res_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_fresh: valid=%b data=%h err=%b want 1 %h 0", res_valid, res_data, res_err, 8'(exp));
    end
    pop();
  endtask

  task automatic test_back_to_back();
    int wait_cyc;
    res_ready = 1'b1;
    send_beat(8'h10, 1'b0);
    send_beat(8'h02, 1'b1);
    tick();
    // 0x0210 = 528, 528 mod 241 = 46
    checks++;
    if (res_valid !== 1'b1 || res_data !== 8'h2E) begin
      errors++;
      $display("FAIL b2b_first: valid=%b data=%h want 1 2e", res_valid, res_data);
    end
    tick();
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_turnaround: res_valid=%b in_ready=%b want 0 1", res_valid, in_ready);
    end
    send_beat(8'h07, 1'b1);
    wait_cyc = 0;
    while (res_valid !== 1'b1 && wait_cyc < 10) begin
      tick();
      wait_cyc++;
    end
    checks++;
    if (res_valid !== 1'b1 || res_data !== 8'h07 || wait_cyc != 1) begin
      errors++;
      $display("FAIL b2b_second: valid=%b data=%h wait=%0d want 1 07 1", res_valid, res_data, wait_cyc);
    end
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    res_ready = 1'b0;
    test_reset();
    test_all_ff();
    test_short();
    test_clear();
    test_framing();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
